// File: rtl/sipo_frame_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_frame_deserializer
//
// Serial-in / parallel-out shift register with framing. Serial bits are
// accepted only while d_valid is high. Once DATA_WIDTH bits have been
// accepted, the assembled word is copied to frame_data and announced with a
// one-cycle frame_valid strobe. Bit order is chosen by MSB_FIRST.
//
// Abort priority is rst > clear > d_valid. clear drops the frame in progress
// and zeroes q, but keeps the last completed frame_data.
//
// Optional feature, enabled by defining SIPO_PARITY_CHECK_EN:
//   after the last data bit, one more accepted bit is taken as an even-parity
//   bit. It is not shifted into q. parity_err is reported together with
//   frame_valid. Without the macro there is no PARITY state and parity_err
//   is a constant 0.
// ---------------------------------------------------------------------------
module sipo_frame_deserializer #(
  parameter int DATA_WIDTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            d,
  input  logic                            d_valid,
  input  logic                            clear,
  output logic [DATA_WIDTH-1:0]           q,
  output logic [DATA_WIDTH-1:0]           frame_data,
  output logic                            frame_valid,
  output logic [$clog2(DATA_WIDTH+1)-1:0] bit_cnt,
  output logic                            busy,
  output logic                            parity_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  // Count value on which the last data bit is accepted.
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

`ifdef SIPO_PARITY_CHECK_EN
  // In PARITY, bit_cnt holds at DATA_WIDTH.
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

  // Returns the shift register with one new bit inserted in the configured order.
  function automatic logic [DATA_WIDTH-1:0] shift_in(
    input logic [DATA_WIDTH-1:0] cur,
    input logic                  bit_in
  );
    logic [DATA_WIDTH-1:0] res;
    if (MSB_FIRST) begin
      res = {cur[DATA_WIDTH-2:0], bit_in};
    end else begin
      res = {bit_in, cur[DATA_WIDTH-1:1]};
    end
    return res;
  endfunction

`ifdef SIPO_PARITY_CHECK_EN
  // Even-parity check. Returns 1 when word plus parity bit has odd weight.
  function automatic logic parity_mismatch(
    input logic [DATA_WIDTH-1:0] word,
    input logic                  par_bit
  );
    return (^word) ^ par_bit;
  endfunction
`endif

  state_t                state_q,      state_d;
  logic [DATA_WIDTH-1:0] q_q,          q_d;
  logic [DATA_WIDTH-1:0] frame_data_q, frame_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [CW-1:0]         bit_cnt_q,    bit_cnt_d;
  logic                  busy_q,       busy_d;
`ifdef SIPO_PARITY_CHECK_EN
  logic                  parity_err_q, parity_err_d;
`endif

  // Next-state and next-output logic. Every register defaults to hold, and the strobes default to 0.
  always_comb begin
    state_d       = state_q;
    q_d           = q_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    bit_cnt_d     = bit_cnt_q;
`ifdef SIPO_PARITY_CHECK_EN
    parity_err_d  = 1'b0;
`endif

    if (clear) begin
      // Abort: the bit presented in this cycle is discarded. frame_data is kept.
      state_d   = ST_IDLE;
      q_d       = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (d_valid) begin
            q_d       = shift_in(q_q, d);
            bit_cnt_d = CW'(1);
            state_d   = ST_SHIFT;
          end else begin
            state_d   = ST_IDLE;
          end
        end

        ST_SHIFT: begin
          if (d_valid) begin
            q_d = shift_in(q_q, d);
            if (bit_cnt_q == LAST_CNT) begin
`ifdef SIPO_PARITY_CHECK_EN
              // The data word is complete. The next accepted bit is parity.
              bit_cnt_d = FULL_CNT;
              state_d   = ST_PARITY;
`else
              // Publish the word including the final bit.
              frame_data_d  = shift_in(q_q, d);
              frame_valid_d = 1'b1;
              bit_cnt_d     = '0;
              state_d       = ST_IDLE;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end else begin
            // Gaps of any length are allowed mid-frame.
            state_d = ST_SHIFT;
          end
        end

`ifdef SIPO_PARITY_CHECK_EN
        ST_PARITY: begin
          if (d_valid) begin
            // The parity bit is consumed here. It never enters q.
            frame_data_d  = q_q;
            frame_valid_d = 1'b1;
            parity_err_d  = parity_mismatch(q_q, d);
            bit_cnt_d     = '0;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_PARITY;
          end
        end
`endif

        default: begin
          // An unreachable encoding recovers to a clean idle frame.
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end

    // busy is registered, so it is derived from the next count.
    busy_d = (bit_cnt_d != '0);
  end

  // State and output registers, with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      q_q           <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      bit_cnt_q     <= '0;
      busy_q        <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      q_q           <= q_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      bit_cnt_q     <= bit_cnt_d;
      busy_q        <= busy_d;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign q           = q_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign bit_cnt     = bit_cnt_q;
  assign busy        = busy_q;
`ifdef SIPO_PARITY_CHECK_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// ---------------------------------------------------------------------------
// Testbench for sipo_frame_deserializer (DATA_WIDTH=4).
//
// One MSB-first instance and one LSB-first instance are driven by the same
// stimulus. The reference model keeps the history of accepted bits and a
// frame bit count. From these it derives q, frame_data, frame_valid, bit_cnt,
// busy and parity_err for each bit order.
// ---------------------------------------------------------------------------
module tb_sipo_frame_deserializer;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, d, d_valid, clear;

  logic [W-1:0]  q_m, fd_m, q_l, fd_l;
  logic          fv_m, fv_l, busy_m, busy_l, pe_m, pe_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit       hist[$];   // accepted bits since the last clear or reset, oldest first
  int       m_cnt;     // bits accepted in the current frame
  logic [W-1:0] m_fd_m, m_fd_l;
  logic     m_fv, m_pe;

  sipo_frame_deserializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .clear(clear),
    .q(q_m), .frame_data(fd_m), .frame_valid(fv_m), .bit_cnt(cnt_m),
    .busy(busy_m), .parity_err(pe_m)
  );

  sipo_frame_deserializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .clear(clear),
    .q(q_l), .frame_data(fd_l), .frame_valid(fv_l), .bit_cnt(cnt_l),
    .busy(busy_l), .parity_err(pe_l)
  );

  // The register holds the most recent W bits. A bit of age 0 is the newest.
  function automatic logic [W-1:0] model_q(input bit msb);
    logic [W-1:0] v;
    v = '0;
    for (int age = 0; age < hist.size(); age++) begin
      if (msb) v[age]         = hist[hist.size() - 1 - age];
      else     v[W - 1 - age] = hist[hist.size() - 1 - age];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("q_msb",      32'(q_m),    32'(model_q(1'b1)));
    chk("q_lsb",      32'(q_l),    32'(model_q(1'b0)));
    chk("fd_msb",     32'(fd_m),   32'(m_fd_m));
    chk("fd_lsb",     32'(fd_l),   32'(m_fd_l));
    chk("fv_msb",     32'(fv_m),   32'(m_fv));
    chk("fv_lsb",     32'(fv_l),   32'(m_fv));
    chk("cnt_msb",    32'(cnt_m),  32'(m_cnt));
    chk("cnt_lsb",    32'(cnt_l),  32'(m_cnt));
    chk("busy_msb",   32'(busy_m), 32'(m_cnt != 0));
    chk("busy_lsb",   32'(busy_l), 32'(m_cnt != 0));
    chk("perr_msb",   32'(pe_m),   32'(m_pe));
    chk("perr_lsb",   32'(pe_l),   32'(m_pe));
  endtask

  // Applies one accepted bit to the model.
  task automatic model_accept(input bit b);
    m_fv = 1'b0;
    m_pe = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    if (m_cnt == W) begin
      m_fd_m = model_q(1'b1);
      m_fd_l = model_q(1'b0);
      m_fv   = 1'b1;
      m_pe   = (^m_fd_m) ^ b;
      m_cnt  = 0;
    end else begin
      hist.push_back(b);
      if (hist.size() > W) void'(hist.pop_front());
      m_cnt++;
    end
`else
    hist.push_back(b);
    if (hist.size() > W) void'(hist.pop_front());
    m_cnt++;
    if (m_cnt == W) begin
      m_fd_m = model_q(1'b1);
      m_fd_l = model_q(1'b0);
      m_fv   = 1'b1;
      m_cnt  = 0;
    end
`endif
  endtask

  // Drives one clock cycle, updates the model and checks every output.
  task automatic step(input bit dv, input bit bd, input bit clr);
    d_valid = dv;
    d       = bd;
    clear   = clr;
    @(posedge clk);
    if (clr) begin
      hist.delete();
      m_cnt = 0;
      m_fv  = 1'b0;
      m_pe  = 1'b0;
    end else if (dv) begin
      model_accept(bd);
    end else begin
      m_fv = 1'b0;
      m_pe = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    rst     = 1'b1;
    d_valid = 1'b1;
    d       = 1'($urandom);
    clear   = 1'b0;
    repeat (n) @(posedge clk);
    hist.delete();
    m_cnt  = 0;
    m_fd_m = '0;
    m_fd_l = '0;
    m_fv   = 1'b0;
    m_pe   = 1'b0;
    #1;
    rst = 1'b0;
    check_all();
  endtask

  task automatic send_bits(input logic [W-1:0] bits_first_at_msb, input int gap);
    logic [W-1:0] v;
    v = bits_first_at_msb;
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, v[i], 1'b0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0; d = 1'b0; d_valid = 1'b0; clear = 1'b0;
    hist.delete();
    m_cnt = 0; m_fd_m = '0; m_fd_l = '0; m_fv = 1'b0; m_pe = 1'b0;

    // Reset for two cycles.
    do_reset(2);

`ifndef SIPO_PARITY_CHECK_EN
    // Send 1,0,1,1 back to back. MSB-first gives 1011 and LSB-first gives 1101.
    send_bits(4'b1011, 0);
    chk("s1_fd_msb", 32'(fd_m), 32'h0000_000B);
    chk("s2_fd_lsb", 32'(fd_l), 32'h0000_000D);
    chk("s1_fv",     32'(fv_m), 32'h0000_0001);
    step(1'b0, 1'b0, 1'b0);
    chk("s1_fv_once", 32'(fv_m), 32'h0000_0000);

    // Abort: send 0,1, then clear together with a valid 1.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("s4_q",   32'(q_m),   32'h0000_0000);
    chk("s4_cnt", 32'(cnt_m), 32'h0000_0000);
    chk("s4_fd",  32'(fd_m),  32'h0000_000B);
    send_bits(4'b1111, 0);
    chk("s4_fd_after", 32'(fd_m), 32'h0000_000F);

    // Send 1,1,0,0 with three idle cycles after each bit.
    send_bits(4'b1100, 3);
    chk("s3_fd", 32'(fd_m), 32'h0000_000C);

    // Back to back: 1,0,0,1,0,1,1,0.
    send_bits(4'b1001, 0);
    chk("s5_fd1", 32'(fd_m), 32'h0000_0009);
    send_bits(4'b0110, 0);
    chk("s5_fd2", 32'(fd_m), 32'h0000_0006);
`else
    // Parity: send 1,0,1,1 with a correct parity bit, then with a wrong one.
    send_bits(4'b1011, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("s6_fd",   32'(fd_m), 32'h0000_000B);
    chk("s6_perr", 32'(pe_m), 32'h0000_0000);
    send_bits(4'b1011, 0);
    step(1'b1, 1'b0, 1'b0);
    chk("s6_perr_bad", 32'(pe_m), 32'h0000_0001);
    step(1'b0, 1'b0, 1'b0);
    chk("s6_perr_clr", 32'(pe_m), 32'h0000_0000);
`endif

    // Reset in the middle of a frame.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    do_reset(1);

    // Random traffic with gaps, occasional clear and occasional reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 29) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
